// File: rtl/vga_timing_ctrl.sv
// 640x480@60 Hz VGA timing controller: free-running raster counters, sync
// generation, one-cycle-early pixel requests and active-area gating of rgb.
module vga_timing_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_data_req,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG = 10'(HA);
  localparam logic [9:0] H_ACT_END = 10'(HA + H_VALID);
  localparam logic [9:0] H_REQ_BEG = 10'(HA - 1);
  localparam logic [9:0] H_REQ_END = 10'(HA + H_VALID - 1);
  localparam logic [9:0] V_ACT_BEG = 10'(VA);
  localparam logic [9:0] V_ACT_END = 10'(VA + V_VALID);
  localparam logic [9:0] IDLE_XY   = 10'h3FF;

  logic        run_q, run_d;
  logic [9:0]  cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic h_act, h_req, v_act;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    run_d       = en;
    cnt_h_d     = cnt_h_q;
    cnt_v_d     = cnt_v_q;
    frame_cnt_d = frame_cnt_q;
    if (!run_q) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      if (cnt_v_q == V_LAST) begin
        cnt_v_d     = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        cnt_v_d = cnt_v_q + 10'd1;
      end
    end else begin
      cnt_h_d = cnt_h_q + 10'd1;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the
  // pre-edge values; the reset is in the sensitivity list, making it async.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q       <= 1'b0;
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      run_q       <= run_d;
      cnt_h_q     <= cnt_h_d;
      cnt_v_q     <= cnt_v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Request window leads the display window by one clock to cover the
  // pattern generator's registered output.
  always_comb begin
    h_act        = (cnt_h_q >= H_ACT_BEG) && (cnt_h_q < H_ACT_END);
    h_req        = (cnt_h_q >= H_REQ_BEG) && (cnt_h_q < H_REQ_END);
    v_act        = (cnt_v_q >= V_ACT_BEG) && (cnt_v_q < V_ACT_END);
    hsync        = 1'b0;
    vsync        = 1'b0;
    rgb_valid    = 1'b0;
    pix_data_req = 1'b0;
    frame_start  = 1'b0;
    pix_x        = IDLE_XY;
    pix_y        = IDLE_XY;
    rgb          = '0;
    if (run_q) begin
      hsync        = (cnt_h_q < H_SYNC_W);
      vsync        = (cnt_v_q < V_SYNC_W);
      rgb_valid    = h_act && v_act;
      pix_data_req = h_req && v_act;
      frame_start  = (cnt_h_q == '0) && (cnt_v_q == '0);
      if (pix_data_req) begin
        pix_x = cnt_h_q - H_REQ_BEG;
        pix_y = cnt_v_q - V_ACT_BEG;
      end
      if (rgb_valid) begin
        rgb = pix_data;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance checks line-level timing,
// a shrunken-raster instance checks frame-level behaviour in few cycles.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic        en_d, en_s;
  logic [23:0] pix_data_d, pix_data_s;

  logic [9:0]  pix_x_d, pix_y_d, pix_x_s, pix_y_s;
  logic        pix_data_req_d, hsync_d, vsync_d, rgb_valid_d, frame_start_d;
  logic        pix_data_req_s, hsync_s, vsync_s, rgb_valid_s, frame_start_s;
  logic [23:0] rgb_d, rgb_s;
  logic [15:0] frame_cnt_d, frame_cnt_s;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [48:0] IDLE = {10'h3FF, 10'h3FF, 5'b0, 24'h0};
  wire [48:0] vec_d = {pix_x_d, pix_y_d, pix_data_req_d, hsync_d, vsync_d,
                       rgb_valid_d, frame_start_d, rgb_d};
  wire [48:0] vec_s = {pix_x_s, pix_y_s, pix_data_req_s, hsync_s, vsync_s,
                       rgb_valid_s, frame_start_s, rgb_s};

  always #20 vga_clk = ~vga_clk;

  vga_timing_ctrl dut_d (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en_d), .pix_data(pix_data_d),
    .pix_x(pix_x_d), .pix_y(pix_y_d), .pix_data_req(pix_data_req_d),
    .hsync(hsync_d), .vsync(vsync_d), .rgb_valid(rgb_valid_d), .rgb(rgb_d),
    .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
  );

  // 17 x 12 raster: HA = 7, VA = 5, 204 clocks per frame
  vga_timing_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_VALID(5), .V_FRONT(2)
  ) dut_s (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en_s), .pix_data(pix_data_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_data_req(pix_data_req_s),
    .hsync(hsync_s), .vsync(vsync_s), .rgb_valid(rgb_valid_s), .rgb(rgb_s),
    .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
  );

  // Pattern generator stand-in: colour = requested X, one registered cycle late
  always @(posedge vga_clk) begin
    pix_data_d <= {14'b0, pix_x_d};
    pix_data_s <= {14'b0, pix_x_s};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int h, v;
  int hs0, hs1, vs_n, fs_n, early_n, x_bad, rgb_bad, val_n;
  int first_req_h, last_req_h, first_val_h, last_val_h;
  logic [9:0] first_x, first_y, last_x;
  int fs_bad, val_f0, y_max, y_min;
  logic [15:0] fc_at_204;

  initial begin
    sys_rst_n = 1'b0;
    en_d = 1'b0;
    en_s = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("reset_idle_d", vec_d, IDLE);
    check("reset_idle_s", vec_s, IDLE);
    check("reset_fcnt_d", frame_cnt_d, 16'h0);
    check("reset_fcnt_s", frame_cnt_s, 16'h0);

    sys_rst_n = 1'b1;
    en_d = 1'b1;
    @(negedge vga_clk);
    check("first_run_fstart", frame_start_d, 1'b1);
    check("first_run_hsync", hsync_d, 1'b1);

    // Full-size instance: 36 lines, k = 0 is the (0,0) cycle
    hs0 = 0; hs1 = 0; vs_n = 0; fs_n = 0; early_n = 0; x_bad = 0; rgb_bad = 0;
    val_n = 0; first_req_h = -1; last_req_h = -1; first_val_h = -1; last_val_h = -1;
    first_x = '0; first_y = '0; last_x = '0;
    for (int k = 0; k < 28800; k++) begin
      if (k > 0) @(negedge vga_clk);
      h = k % 800;
      v = k / 800;
      if (v == 0 && hsync_d) hs0++;
      if (v == 1 && hsync_d) hs1++;
      if (vsync_d) vs_n++;
      if (k > 0 && frame_start_d) fs_n++;
      if (v < 35 && (pix_data_req_d || rgb_valid_d)) early_n++;
      if (k == 800) check("line_wrap_hsync", {hsync_d, vsync_d}, 2'b11);
      if (v == 35) begin
        if (pix_data_req_d) begin
          if (first_req_h < 0) begin
            first_req_h = h;
            first_x = pix_x_d;
            first_y = pix_y_d;
          end
          last_req_h = h;
          last_x = pix_x_d;
          if (pix_x_d != 10'(h - 143) || pix_y_d != 10'd0) x_bad++;
        end else if (pix_x_d != 10'h3FF || pix_y_d != 10'h3FF) begin
          x_bad++;
        end
        if (rgb_valid_d) begin
          if (first_val_h < 0) first_val_h = h;
          last_val_h = h;
          val_n++;
          if (rgb_d != 24'(h - 144)) rgb_bad++;
        end else if (rgb_d != 24'h0) begin
          rgb_bad++;
        end
      end
    end
    check("hsync_width_l0", hs0, 96);
    check("hsync_width_l1", hs1, 96);
    check("vsync_width", vs_n, 1600);
    check("no_stray_fstart", fs_n, 0);
    check("no_req_in_blank", early_n, 0);
    check("first_req_h", first_req_h, 143);
    check("first_req_xy", {first_x, first_y}, 20'h0);
    check("first_valid_h", first_val_h, 144);
    check("last_req_h", last_req_h, 782);
    check("last_req_x", last_x, 10'd639);
    check("last_valid_h", last_val_h, 783);
    check("valid_per_line", val_n, 640);
    check("pix_xy_bad", x_bad, 0);
    check("rgb_bad_l35", rgb_bad, 0);
    en_d = 1'b0;

    // Shrunken instance: three frames
    en_s = 1'b1;
    @(negedge vga_clk);
    fs_bad = 0; val_f0 = 0; y_max = -1; y_min = 1000; rgb_bad = 0; fc_at_204 = '0;
    for (int k = 0; k < 612; k++) begin
      if (k > 0) @(negedge vga_clk);
      h = k % 17;
      v = (k / 17) % 12;
      if (frame_start_s != (h == 0 && v == 0)) fs_bad++;
      if (k == 204) fc_at_204 = frame_cnt_s;
      if (k < 204 && rgb_valid_s) val_f0++;
      if (pix_data_req_s) begin
        if (int'(pix_y_s) > y_max) y_max = int'(pix_y_s);
        if (int'(pix_y_s) < y_min) y_min = int'(pix_y_s);
      end
      if (rgb_valid_s) begin
        if (rgb_s != 24'(h - 7)) rgb_bad++;
      end else if (rgb_s != 24'h0) begin
        rgb_bad++;
      end
    end
    @(negedge vga_clk);
    check("s_fstart_period", fs_bad, 0);
    check("s_fcnt_after_f0", fc_at_204, 16'd1);
    check("s_valid_per_frame", val_f0, 40);
    check("s_pix_y_range", {y_min[9:0], y_max[9:0]}, {10'd0, 10'd4});
    check("s_rgb_bad", rgb_bad, 0);
    check("s_fcnt_3", frame_cnt_s, 16'd3);
    check("s_fstart_f3", frame_start_s, 1'b1);

    // Drop en mid-frame at (h=9, v=6), inside the active area
    repeat (111) @(negedge vga_clk);
    check("s_active_before_drop", {rgb_valid_s, pix_y_s}, {1'b1, 10'd1});
    en_s = 1'b0;
    @(negedge vga_clk);
    check("s_idle_after_drop", vec_s, IDLE);
    repeat (3) @(negedge vga_clk);
    check("s_fcnt_after_abort", frame_cnt_s, 16'd3);
    en_s = 1'b1;
    @(negedge vga_clk);
    check("s_fstart_on_reen", {frame_start_s, hsync_s}, 2'b11);
    check("s_fcnt_on_reen", frame_cnt_s, 16'd3);

    // Preload the frame counter just below wrap, then finish the frame
    force dut_s.frame_cnt_q = 16'hFFFF;
    @(negedge vga_clk);
    release dut_s.frame_cnt_q;
    repeat (202) @(negedge vga_clk);
    check("s_fcnt_pre_wrap", frame_cnt_s, 16'hFFFF);
    @(negedge vga_clk);
    check("s_fcnt_wrap", frame_cnt_s, 16'h0);
    check("s_fstart_wrap", frame_start_s, 1'b1);

    // Asynchronous reset mid-line, well away from any clock edge
    repeat (111) @(negedge vga_clk);
    check("s_active_before_rst", rgb_valid_s, 1'b1);
    @(posedge vga_clk);
    #5;
    sys_rst_n = 1'b0;
    #1;
    check("s_async_rst_idle", vec_s, IDLE);
    check("s_async_rst_fcnt", frame_cnt_s, 16'h0);
    check("d_async_rst_idle", vec_d, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
